// File: rtl/i2c_codec_init_sequencer.sv
// WM8731 power-up register loader: walks a fixed write table through an
// external I2cMaster, retrying NACK / clock-stretch timeouts per entry.
module i2c_codec_init_sequencer #(
   parameter int unsigned ClockFrequency     = 24_000_000,
   parameter logic [6:0]  DeviceAddress      = 7'h1A,
   parameter int unsigned PowerUpDelayCycles = ClockFrequency / 1000,
   parameter int unsigned GapCycles          = 240,
   parameter int unsigned BusyTimeoutCycles  = 16,
   parameter int unsigned MaxRetries         = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        restart,
   input  logic        masterReady,
   input  logic        masterNoAck,
   input  logic        masterStretchTo,
   output logic        start,
   output logic [6:0]  address,
   output logic [1:0]  nrOfBytesToSend,
   output logic [1:0]  nrOfBytesToRead,
   output logic [15:0] bytesToSend,
   output logic [3:0]  entryIndex,
   output logic        done,
   output logic        error
);

   localparam int unsigned MaxPG =
      (PowerUpDelayCycles > GapCycles) ? PowerUpDelayCycles : GapCycles;
   localparam int unsigned CntMax =
      (MaxPG > BusyTimeoutCycles) ? MaxPG : BusyTimeoutCycles;
   localparam int CntW   = (CntMax > 1) ? $clog2(CntMax + 1) : 1;
   localparam int RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

   localparam logic [CntW-1:0]   CntOne    = CntW'(1);
   localparam logic [CntW-1:0]   PuLast    = CntW'(PowerUpDelayCycles - 1);
   localparam logic [CntW-1:0]   GapLast   = CntW'(GapCycles - 1);
   localparam logic [CntW-1:0]   ToLast    = CntW'(BusyTimeoutCycles - 1);
   localparam logic [RetryW-1:0] RetryMax  = RetryW'(MaxRetries);
   localparam logic [RetryW-1:0] RetryOne  = RetryW'(1);
   localparam logic [3:0]        LastEntry = 4'd10;
   localparam logic [3:0]        EntryOne  = 4'd1;

   typedef enum logic [2:0] {
      POWER_UP,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      GAP,
      DONE,
      FAILED
   } state_t;

   state_t            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [RetryW-1:0] retry_q;
   logic [3:0]        entry_q;
   logic [15:0]       bytes_q;
   logic              start_q;
   logic              done_q;
   logic              error_q;
   logic              ok_q;

   logic              attemptFail;
   logic              attemptOk;
   logic              xferBad;

   // Each word is {register[6:0], data[8:0]}; entry 0 resets the codec,
   // entry 10 activates the digital interface last.
   function automatic logic [15:0] entryWord(input logic [3:0] idx);
      logic [15:0] w;
      case (idx)
         4'd0:    w = {7'h0F, 9'h000};
         4'd1:    w = {7'h00, 9'h017};
         4'd2:    w = {7'h01, 9'h017};
         4'd3:    w = {7'h02, 9'h079};
         4'd4:    w = {7'h03, 9'h079};
         4'd5:    w = {7'h04, 9'h012};
         4'd6:    w = {7'h05, 9'h000};
         4'd7:    w = {7'h06, 9'h000};
         4'd8:    w = {7'h07, 9'h042};
         4'd9:    w = {7'h08, 9'h000};
         4'd10:   w = {7'h09, 9'h001};
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

   always_comb begin
      xferBad     = masterNoAck | masterStretchTo;
      attemptFail = 1'b0;
      attemptOk   = 1'b0;
      if (state_q == WAIT_BUSY && masterReady && cnt_q == ToLast) begin
         attemptFail = 1'b1;
      end
      if (state_q == WAIT_DONE && masterReady) begin
         attemptFail = xferBad;
         attemptOk   = !xferBad;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= POWER_UP;
         cnt_q   <= '0;
         retry_q <= '0;
         entry_q <= '0;
         bytes_q <= entryWord(4'd0);
         start_q <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         unique case (state_q)
            POWER_UP: begin
               if (cnt_q == PuLast) begin
                  cnt_q   <= '0;
                  state_q <= ISSUE;
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
            end
            ISSUE: begin
               if (start_q) begin
                  start_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= WAIT_BUSY;
               end else if (masterReady) begin
                  start_q <= 1'b1;
               end
            end
            WAIT_BUSY: begin
               if (!masterReady) begin
                  cnt_q   <= '0;
                  state_q <= WAIT_DONE;
               end else if (!attemptFail) begin
                  cnt_q <= cnt_q + CntOne;
               end
            end
            WAIT_DONE: begin
               if (attemptOk) begin
                  ok_q    <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (cnt_q == GapLast) begin
                  cnt_q   <= '0;
                  state_q <= ISSUE;
                  if (ok_q) begin
                     if (entry_q == LastEntry) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        entry_q <= entry_q + EntryOne;
                        bytes_q <= entryWord(entry_q + EntryOne);
                        retry_q <= '0;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
            end
            DONE, FAILED: begin
               if (restart) begin
                  state_q <= POWER_UP;
                  cnt_q   <= '0;
                  retry_q <= '0;
                  entry_q <= '0;
                  bytes_q <= entryWord(4'd0);
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
               end
            end
            default: state_q <= POWER_UP;
         endcase
         // A failed attempt overrides the per-state transitions above.
         if (attemptFail) begin
            cnt_q <= '0;
            ok_q  <= 1'b0;
            if (retry_q < RetryMax) begin
               retry_q <= retry_q + RetryOne;
               state_q <= GAP;
            end else begin
               state_q <= FAILED;
               error_q <= 1'b1;
            end
         end
      end
   end

   assign start           = start_q;
   assign address         = DeviceAddress;
   assign nrOfBytesToSend = 2'd2;
   assign nrOfBytesToRead = 2'd0;
   assign bytesToSend     = bytes_q;
   assign entryIndex      = entry_q;
   assign done            = done_q;
   assign error           = error_q;

endmodule

// File: tb/tb_i2c_codec_init_sequencer.sv
// Directed bench for i2c_codec_init_sequencer with a behavioural
// I2cMaster that can ack, NACK, stretch-time-out or ignore start.
module tb_i2c_codec_init_sequencer;

   localparam int P = 20;
   localparam int G = 5;
   localparam int T = 16;
   localparam logic [15:0] EXP [0:10] = '{
      16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
      16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201
   };

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        restart = 1'b0;
   logic        ready = 1'b1;
   logic        noack = 1'b0;
   logic        stto = 1'b0;
   logic        start;
   logic [6:0]  address;
   logic [1:0]  nSend;
   logic [1:0]  nRead;
   logic [15:0] bytesToSend;
   logic [3:0]  entryIndex;
   logic        done;
   logic        error;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [15:0] caps [$];
   int          capt [$];
   logic        ignore = 1'b0;
   logic        use_stretch = 1'b0;
   logic [15:0] nack_word = 16'hFFFF;
   int          nack_left = 0;
   logic [15:0] cur;
   logic        fail_now;

   i2c_codec_init_sequencer #(
      .PowerUpDelayCycles(P),
      .GapCycles(G),
      .BusyTimeoutCycles(T),
      .MaxRetries(3)
   ) dut (
      .clock(clk),
      .reset(reset),
      .restart(restart),
      .masterReady(ready),
      .masterNoAck(noack),
      .masterStretchTo(stto),
      .start(start),
      .address(address),
      .nrOfBytesToSend(nSend),
      .nrOfBytesToRead(nRead),
      .bytesToSend(bytesToSend),
      .entryIndex(entryIndex),
      .done(done),
      .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!reset) begin
         assert (!(done && error)) else begin
            failures++;
            $error("FAIL done_error_both got=%b%b exp=not both", done, error);
         end
      end
   end

   // I2cMaster model: ready drops after start, returns 3 cycles later.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (start && ready && !reset) begin
            cur = bytesToSend;
            caps.push_back(cur);
            capt.push_back(cyc);
            if (!ignore) begin
               ready = 1'b0;
               noack = 1'b0;
               stto = 1'b0;
               repeat (3) @(posedge clk);
               #1;
               fail_now = (cur == nack_word) && (nack_left != 0);
               if (fail_now && nack_left > 0) nack_left--;
               noack = fail_now && !use_stretch;
               stto = fail_now && use_stretch;
               ready = 1'b1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_end(input int budget, input string tag);
      int n;
      n = 0;
      while (!(done || error) && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      check(tag, 32'(done || error), 1);
   endtask

   task automatic wait_starts(input int k, input int budget,
                              input string tag);
      int n;
      n = 0;
      while (caps.size() < k && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      check(tag, caps.size(), k);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
   endtask

   function automatic int count_word(input logic [15:0] w);
      int c;
      c = 0;
      foreach (caps[i]) if (caps[i] == w) c++;
      return c;
   endfunction

   initial begin
      // Reset values and first-start latency
      repeat (3) @(posedge clk);
      #1;
      check("rst_start", start, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_entry", entryIndex, 0);
      check("rst_bytes", bytesToSend, 16'h1E00);
      check("addr", address, 7'h1A);
      check("nsend", nSend, 2);
      check("nread", nRead, 0);
      reset = 1'b0;
      repeat (P) @(posedge clk);
      #1;
      check("pu_early", start, 0);
      @(posedge clk);
      #1;
      check("pu_start", start, 1);
      check("pu_bytes", bytesToSend, 16'h1E00);

      // 1: all acked
      wait_end(1000, "t1_timeout");
      check("t1_done", done, 1);
      check("t1_error", error, 0);
      check("t1_count", caps.size(), 11);
      for (int i = 0; i < 11 && i < caps.size(); i++) begin
         check($sformatf("t1_word%0d", i), caps[i], EXP[i]);
      end
      repeat (50) @(posedge clk);
      #1;
      check("t1_idle", caps.size(), 11);
      check("t1_hold", done, 1);

      // 5: restart in DONE, then restart while busy is ignored
      caps.delete();
      capt.delete();
      pulse_restart();
      check("t5_done_clr", done, 0);
      check("t5_entry_clr", entryIndex, 0);
      repeat (P) @(posedge clk);
      #1;
      check("t5_early", start, 0);
      @(posedge clk);
      #1;
      check("t5_start", start, 1);
      check("t5_bytes", bytesToSend, 16'h1E00);
      wait_starts(3, 500, "t5_wait3");
      pulse_restart();
      check("t5_busy_entry", entryIndex, 2);
      wait_end(1000, "t5_timeout");
      check("t5_done", done, 1);
      check("t5_count", caps.size(), 11);

      // 2: entry 3 fails twice (stretch timeout), then acks
      caps.delete();
      capt.delete();
      nack_word = 16'h0479;
      nack_left = 2;
      use_stretch = 1'b1;
      pulse_restart();
      wait_end(1500, "t2_timeout");
      check("t2_done", done, 1);
      check("t2_error", error, 0);
      check("t2_e3", count_word(16'h0479), 3);
      check("t2_count", caps.size(), 13);
      if (caps.size() == 13) check("t2_last", caps[12], 16'h1201);

      // 3: entry 5 NACKs forever
      caps.delete();
      capt.delete();
      nack_word = 16'h0812;
      nack_left = -1;
      use_stretch = 1'b0;
      pulse_restart();
      wait_end(1500, "t3_timeout");
      check("t3_error", error, 1);
      check("t3_done", done, 0);
      check("t3_entry", entryIndex, 5);
      check("t3_e5", count_word(16'h0812), 4);
      check("t3_count", caps.size(), 9);
      repeat (100) @(posedge clk);
      #1;
      check("t3_idle", caps.size(), 9);
      check("t3_hold", error, 1);

      // 4: master ignores start; restart from FAILED
      caps.delete();
      capt.delete();
      nack_left = 0;
      ignore = 1'b1;
      pulse_restart();
      check("t4_err_clr", error, 0);
      wait_starts(4, 1000, "t4_wait4");
      repeat (T) @(posedge clk);
      #1;
      check("t4_err_early", error, 0);
      @(posedge clk);
      #1;
      check("t4_err", error, 1);
      check("t4_done", done, 0);
      check("t4_entry", entryIndex, 0);
      if (capt.size() >= 2) check("t4_space", capt[1] - capt[0], 18 + G);
      repeat (60) @(posedge clk);
      #1;
      check("t4_count", caps.size(), 4);

      // 6: reset during WAIT_DONE of entry 7
      caps.delete();
      capt.delete();
      ignore = 1'b0;
      pulse_restart();
      wait_starts(8, 1500, "t6_wait8");
      @(posedge clk);
      @(posedge clk);
      #1;
      check("t6_entry7", entryIndex, 7);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t6_rst_start", start, 0);
      check("t6_rst_entry", entryIndex, 0);
      check("t6_rst_bytes", bytesToSend, 16'h1E00);
      check("t6_rst_flags", {30'd0, done, error}, 0);
      caps.delete();
      capt.delete();
      reset = 1'b0;
      repeat (P) @(posedge clk);
      #1;
      check("t6_early", start, 0);
      @(posedge clk);
      #1;
      check("t6_start", start, 1);
      wait_end(1000, "t6_timeout");
      check("t6_done", done, 1);
      check("t6_count", caps.size(), 11);
      if (caps.size() > 0) check("t6_first", caps[0], 16'h1E00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
